// File: rtl/yuv_stream_gearbox_pkg.sv
// rtl/yuv_stream_gearbox_pkg.sv - shared serialiser state type and beat-count helper
package yuv_stream_gearbox_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    function automatic int beats_per_word(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

endpackage

// File: rtl/yuv_stream_gearbox_fifo.sv
// rtl/yuv_stream_gearbox_fifo.sv - tagged word FIFO with fall-through read and occupancy level
module sync_fifo_tagged #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);

    // A write into a full FIFO is only taken when the same cycle frees a slot.
    assign w_wr = wr_en_i && (!w_full || rd_en_i) && !flush_i;
    assign w_rd = rd_en_i && !w_empty && !flush_i;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data_o = r_mem[r_rd_ptr];
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign level_o   = r_level;

endmodule

// File: rtl/yuv_stream_gearbox.sv
// rtl/yuv_stream_gearbox.sv - stages YUV422 input words, buffers them and serialises to narrow beats
module yuv_stream_gearbox
    import yuv_stream_gearbox_pkg::*;
#(
    parameter int IN_WIDTH   = 128,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          frame_start_i,
    input  logic                          line_valid_i,
    input  logic [IN_WIDTH-1:0]           data_i,
    input  logic                          data_valid_i,
    input  logic                          swap_i,
    input  logic                          ready_i,
    output logic [OUT_WIDTH-1:0]          data_o,
    output logic                          output_valid_o,
    output logic                          line_end_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int BEATS = beats_per_word(IN_WIDTH, OUT_WIDTH);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [IN_WIDTH-1:0]          r_stage_data;
    logic                         r_stage_valid;
    logic                         r_overflow;

    ser_state_t                   r_state;
    logic [IN_WIDTH-1:0]          r_shift;
    logic [CW-1:0]                r_cnt;
    logic                         r_tag;
    logic [OUT_WIDTH-1:0]         r_data;
    logic                         r_valid;
    logic                         r_line_end;

    logic                         w_commit;
    logic                         w_tag;
    logic                         w_pop;
    logic                         w_beat_take;
    logic                         w_last_beat;
    logic [IN_WIDTH:0]            w_fifo_rdata;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_fifo_level;
    logic [OUT_WIDTH-1:0]         w_load_beat;
    logic [OUT_WIDTH-1:0]         w_next_beat;

    function automatic logic [OUT_WIDTH-1:0] f_present(input logic [OUT_WIDTH-1:0] beat,
                                                       input logic swap);
        logic [OUT_WIDTH-1:0] rev;
        rev = '0;
        for (int b = 0; b < OUT_WIDTH / 8; b++) begin
            rev[8*b +: 8] = beat[OUT_WIDTH-8-8*b +: 8];
        end
        return swap ? rev : beat;
    endfunction

    // The staged word leaves either on the next word (untagged) or at line end (tagged).
    assign w_commit = r_stage_valid && (data_valid_i || !line_valid_i) && !frame_start_i;
    assign w_tag    = !data_valid_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_stage_data  <= '0;
            r_stage_valid <= 1'b0;
        end else if (frame_start_i) begin
            r_stage_data  <= data_i;
            r_stage_valid <= data_valid_i;
        end else if (data_valid_i) begin
            r_stage_data  <= data_i;
            r_stage_valid <= 1'b1;
        end else if (w_commit) begin
            r_stage_valid <= 1'b0;
        end
    end

    sync_fifo_tagged #(
        .WIDTH (IN_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush_i   (frame_start_i),
        .wr_en_i   (w_commit),
        .wr_data_i ({w_tag, r_stage_data}),
        .rd_en_i   (w_pop),
        .rd_data_o (w_fifo_rdata),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty),
        .level_o   (w_fifo_level)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_overflow <= 1'b0;
        end else if (frame_start_i) begin
            r_overflow <= 1'b0;
        end else if (w_commit && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_beat_take = r_valid && ready_i;
    assign w_last_beat = (r_cnt == '0);
    // Reloading on the final accepted beat keeps consecutive words bubble-free.
    assign w_pop       = !frame_start_i && !w_fifo_empty &&
                         ((r_state == ST_IDLE) || (w_beat_take && w_last_beat));
    assign w_load_beat = f_present(w_fifo_rdata[IN_WIDTH-1 -: OUT_WIDTH], swap_i);
    assign w_next_beat = f_present(r_shift[IN_WIDTH-1 -: OUT_WIDTH], swap_i);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tag      <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_line_end <= 1'b0;
        end else if (frame_start_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tag      <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_line_end <= 1'b0;
        end else if (w_pop) begin
            r_state    <= ST_SHIFT;
            r_shift    <= w_fifo_rdata[IN_WIDTH-1:0] << OUT_WIDTH;
            r_cnt      <= CW'(BEATS - 1);
            r_tag      <= w_fifo_rdata[IN_WIDTH];
            r_data     <= w_load_beat;
            r_valid    <= 1'b1;
            r_line_end <= w_fifo_rdata[IN_WIDTH] && (BEATS == 1);
        end else if (w_beat_take) begin
            if (!w_last_beat) begin
                r_shift    <= r_shift << OUT_WIDTH;
                r_cnt      <= r_cnt - 1'b1;
                r_data     <= w_next_beat;
                r_line_end <= r_tag && (r_cnt == CW'(1));
            end else begin
                r_state    <= ST_IDLE;
                r_data     <= '0;
                r_valid    <= 1'b0;
                r_line_end <= 1'b0;
                r_tag      <= 1'b0;
            end
        end
    end

    assign data_o         = r_data;
    assign output_valid_o = r_valid;
    assign line_end_o     = r_line_end;
    assign overflow_o     = r_overflow;
    assign level_o        = w_fifo_level;

endmodule
